// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   md_op values : MD_* encodings carried on the 3-bit Op field (6,7 reserved)
//   md_state_e   : sequencing states of md_unit
//   MD_*_CYCLES  : default Busy durations for multiply and divide
package md_unit_pkg;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_mult(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_alu.sv
// Combinational arithmetic core of the multiply/divide unit.
//   op       in  3   MD_* operation
//   a, b     in  32  rs / rt operands
//   res_hi   out 32  HI half of the result (product high word or remainder)
//   res_lo   out 32  LO half of the result (product low word or quotient)
//   div_zero out 1   divide op with b==0; caller keeps the old HI/LO
module md_unit_alu
  import md_unit_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic [31:0]        res_hi,
  output logic [31:0]        res_lo,
  output logic               div_zero
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_ovf;
  logic signed [31:0] sa;
  logic signed [31:0] sb_safe;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        ub_safe;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Most-negative / -1 overflows the quotient; the divisor is forced to 1
  // so the divider never sees that case (or a zero divisor).
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign div_zero = md_is_div(op) && (b == 32'd0);

  assign sa      = $signed(a);
  assign sb_safe = (b == 32'd0 || div_ovf) ? 32'sd1 : $signed(b);
  assign q_s     = sa / sb_safe;
  assign r_s     = sa % sb_safe;

  assign ub_safe = (b == 32'd0) ? 32'd1 : b;
  assign q_u     = a / ub_safe;
  assign r_u     = a % ub_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (div_ovf) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = q_s;
          res_hi = r_s;
        end
      end
      MD_DIVU: begin
        res_lo = q_u;
        res_hi = r_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit holding architectural HI/LO.
//   Clock in  1   single clock, posedge
//   Reset in  1   synchronous active-low clear of all state
//   Start in  1   E-stage MD instruction this cycle
//   Op    in  3   MD_* operation
//   A, B  in  32  rs / rt operands
//   Busy  out 1   multi-cycle op in flight
//   HI    out 32  architectural HI
//   LO    out 32  architectural LO
//
//   state | meaning
//   IDLE  | accepts Start; MTHI/MTLO write directly, mult/div launch
//   RUN   | Busy high, count N..1; HI/LO loaded from res_* when count==1
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [MD_OP_W-1:0] Op,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  output logic               Busy,
  output logic [31:0]        HI,
  output logic [31:0]        LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e          state_q, state_n;
  logic [CNT_W-1:0]   count_q, count_n;
  logic [31:0]        hi_q, hi_n, lo_q, lo_n;
  logic [31:0]        res_hi_q, res_hi_n, res_lo_q, res_lo_n;
  logic [31:0]        alu_hi, alu_lo;
  logic               alu_div_zero;

  md_unit_alu u_alu (
    .op       (Op),
    .a        (A),
    .b        (B),
    .res_hi   (alu_hi),
    .res_lo   (alu_lo),
    .div_zero (alu_div_zero)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= MD_IDLE;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      hi_q     <= hi_n;
      lo_q     <= lo_n;
      res_hi_q <= res_hi_n;
      res_lo_q <= res_lo_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    hi_n     = hi_q;
    lo_n     = lo_q;
    res_hi_n = res_hi_q;
    res_lo_n = res_lo_q;
    case (state_q)
      MD_IDLE: begin
        if (Start) begin
          if (md_is_mult(Op)) begin
            res_hi_n = alu_hi;
            res_lo_n = alu_lo;
            count_n  = CNT_W'(MULT_CYCLES);
            state_n  = MD_RUN;
          end else if (md_is_div(Op)) begin
            // HI/LO cannot change while RUN, so capturing them here makes
            // the divide-by-zero commit a no-op.
            res_hi_n = alu_div_zero ? hi_q : alu_hi;
            res_lo_n = alu_div_zero ? lo_q : alu_lo;
            count_n  = CNT_W'(DIV_CYCLES);
            state_n  = MD_RUN;
          end else if (Op == MD_MTHI) begin
            hi_n = A;
          end else if (Op == MD_MTLO) begin
            lo_n = A;
          end
        end
      end
      MD_RUN: begin
        if (count_q == CNT_W'(1)) begin
          hi_n    = res_hi_q;
          lo_n    = res_lo_q;
          count_n = '0;
          state_n = MD_IDLE;
        end else begin
          count_n = count_q - CNT_W'(1);
        end
      end
      default: state_n = MD_IDLE;
    endcase
  end

  assign Busy = (state_q == MD_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_unit_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op    = 3'd0;
  logic [31:0] A     = 32'd0;
  logic [31:0] B     = 32'd0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Launch one op, scramble A/B while it runs, count Busy cycles, check commit.
  task automatic run_md(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_cyc, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    Start = 1'b1; Op = op; A = a; B = b;
    step();
    Start = 1'b0;
    n = 0;
    while (Busy && n < 40) begin
      n++;
      A = $urandom;
      B = $urandom;
      step();
    end
    chk({tag, " busy_cycles"}, 32'(n), 32'(exp_cyc));
    chk({tag, " hi"}, HI, exp_hi);
    chk({tag, " lo"}, LO, exp_lo);
  endtask

  task automatic write_hl(input logic [2:0] op, input logic [31:0] v);
    Start = 1'b1; Op = op; A = v;
    step();
    Start = 1'b0;
  endtask

  initial begin
    // 1: reset with a Start asserted must not write anything
    Reset = 1'b0; Start = 1'b1; Op = MD_MTHI; A = 32'h55;
    step(); step();
    chk("rst_hi_held", HI, 32'd0);
    Start = 1'b0; Reset = 1'b1;
    step();
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);

    // 2: multiplies
    run_md("mult", MD_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);

    // 3: divides
    run_md("div", MD_DIV,  32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu", MD_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_md("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

    // 4: divide by zero keeps HI/LO; overflow case
    write_hl(MD_MTHI, 32'h11);
    write_hl(MD_MTLO, 32'h22);
    chk("mt_hi", HI, 32'h11);
    chk("mt_lo", LO, 32'h22);
    run_md("div0", MD_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22);
    run_md("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // 5: MTHI one cycle; reserved op ignored; MTLO during RUN ignored
    Start = 1'b1; Op = MD_MTHI; A = 32'hDEAD_BEEF;
    step();
    Start = 1'b0;
    chk("mthi_hi", HI, 32'hDEAD_BEEF);
    chk("mthi_busy", 32'(Busy), 32'd0);
    chk("mthi_lo", LO, 32'h8000_0000);
    Start = 1'b1; Op = 3'd6; A = 32'h1; B = 32'h1;
    step();
    Start = 1'b0;
    chk("rsv_hi", HI, 32'hDEAD_BEEF);
    chk("rsv_lo", LO, 32'h8000_0000);
    chk("rsv_busy", 32'(Busy), 32'd0);
    begin
      int n;
      Start = 1'b1; Op = MD_MULTU; A = 32'd2; B = 32'd3;
      step();
      Op = MD_MTLO; A = 32'h1234;   // Start still high during RUN
      step();
      Start = 1'b0;
      chk("mtlo_run_lo", LO, 32'h8000_0000);
      n = 1;
      while (Busy && n < 40) begin
        n++;
        step();
      end
      chk("mtlo_run_busy", 32'(n), 32'd5);
      chk("mtlo_run_hi", HI, 32'd0);
      chk("mtlo_run_lo2", LO, 32'd6);
    end

    // 6: reset while count==2 aborts; then operand-sampling check
    Start = 1'b1; Op = MD_MULT; A = 32'd7; B = 32'd9;
    step();                       // count=5
    Start = 1'b0;
    A = 32'hAAAA; B = 32'h5555; step();   // count=4
    A = 32'h1234; B = 32'h4321; step();   // count=3
    A = 32'hFFFF; B = 32'h0F0F; step();   // count=2
    chk("abort_busy_pre", 32'(Busy), 32'd1);
    Reset = 1'b0;
    step();
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    Reset = 1'b1;
    step(); step();
    chk("abort_lo_stays", LO, 32'd0);
    run_md("sample", MD_MULT, 32'd7, 32'd9, 5, 32'd0, 32'd63);
    run_md("sample_neg", MD_MULT, 32'hFFFF_FFF9, 32'd9, 5, 32'hFFFF_FFFF, 32'hFFFF_FFC1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
